// File: rtl/axis_info_pkt_mux_if.sv
// AXI-Stream link bundle (32-bit data, tlast) used on both sides of the info packet mux.
interface axis_info_pkt_mux_if;
  logic [31:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_info_pkt_mux.sv
// Drains the Zynq TX FIFO onto the ASIC link stream and inserts 4-word info packets between frames.
// States: IDLE | packet boundary, one-cycle decision; PASS | forwarding a Zynq frame; INFO | emitting info words 0..3
module axis_info_pkt_mux #(
  parameter logic [7:0] INFO_MAGIC   = 8'hA5,
  parameter logic [7:0] INFO_VERSION = 8'h01
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_info_pkt_mux_if.slave         s_axis,
  axis_info_pkt_mux_if.master        m_axis,
  input  logic                       info_req,
  output logic                       info_sent,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    INFO = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  info_idx_q, info_idx_d;
  logic        pending_q;
  logic [31:0] timestamp_q;
  logic [31:0] frame_cnt_q;
  logic [31:0] word_cnt_q;
  logic [15:0] seq_q;
  logic [31:0] snap_ts_q;
  logic [31:0] snap_frames_q;
  logic [31:0] snap_words_q;

  logic [31:0] out_data_q;
  logic        out_last_q;
  logic        out_valid_q;
  logic        out_info_q;

  logic        slot_free;
  logic        in_fire;
  logic        take_info;
  logic        load;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_info;
  logic        seq_inc;
  logic [31:0] info_word;

  // The output register may be refilled when it is empty or its word leaves this cycle.
  assign slot_free     = !out_valid_q || m_axis.tready;
  assign s_axis.tready = (state_q == PASS) && slot_free;
  assign in_fire       = s_axis.tvalid && s_axis.tready;

  assign m_axis.tdata  = out_data_q;
  assign m_axis.tlast  = out_last_q;
  assign m_axis.tvalid = out_valid_q;

  assign info_sent = out_valid_q && m_axis.tready && out_last_q && out_info_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    case (info_idx_q)
      2'd0:    info_word = {INFO_MAGIC, INFO_VERSION, seq_q};
      2'd1:    info_word = snap_ts_q;
      2'd2:    info_word = snap_frames_q;
      default: info_word = snap_words_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    info_idx_d = info_idx_q;
    take_info  = 1'b0;
    load       = 1'b0;
    load_data  = s_axis.tdata;
    load_last  = s_axis.tlast;
    load_info  = 1'b0;
    seq_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d    = INFO;
          take_info  = 1'b1;
          info_idx_d = 2'd0;
        end else if (s_axis.tvalid) begin
          state_d = PASS;
        end
      end
      PASS: begin
        if (in_fire) begin
          load = 1'b1;
          if (s_axis.tlast) state_d = IDLE;
        end
      end
      INFO: begin
        if (slot_free) begin
          load       = 1'b1;
          load_data  = info_word;
          load_last  = (info_idx_q == 2'd3);
          load_info  = 1'b1;
          info_idx_d = info_idx_q + 2'd1;
          if (info_idx_q == 2'd3) begin
            state_d = IDLE;
            seq_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      info_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      info_idx_q <= info_idx_d;
    end
  end

  // A request arriving in the same cycle the packet is taken starts a fresh pending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= (pending_q && !take_info) || info_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timestamp_q <= 32'd0;
      word_cnt_q  <= 32'd0;
      frame_cnt_q <= 32'd0;
      seq_q       <= 16'd0;
    end else begin
      timestamp_q <= timestamp_q + 32'd1;
      if (in_fire)                  word_cnt_q  <= word_cnt_q + 32'd1;
      if (in_fire && s_axis.tlast)  frame_cnt_q <= frame_cnt_q + 32'd1;
      if (seq_inc)                  seq_q       <= seq_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_ts_q     <= 32'd0;
      snap_frames_q <= 32'd0;
      snap_words_q  <= 32'd0;
    end else if (take_info) begin
      snap_ts_q     <= timestamp_q;
      snap_frames_q <= frame_cnt_q;
      snap_words_q  <= word_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= 32'd0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_info_q  <= 1'b0;
    end else if (load) begin
      out_data_q  <= load_data;
      out_last_q  <= load_last;
      out_valid_q <= 1'b1;
      out_info_q  <= load_info;
    end else if (slot_free) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_info_pkt_mux.sv
// Self-checking bench for axis_info_pkt_mux: cycle vector table, directed corner cases, random scoreboard.
module tb_axis_info_pkt_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic info_req = 1'b0;
  logic info_sent;
  logic busy;

  axis_info_pkt_mux_if s_axis ();
  axis_info_pkt_mux_if m_axis ();

  axis_info_pkt_mux dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_axis),
    .m_axis    (m_axis),
    .info_req  (info_req),
    .info_sent (info_sent),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycles since reset release; the DUT timestamp must equal this.
  logic [31:0] ts_model;
  always @(posedge clk or posedge rst) begin
    if (rst) ts_model <= 32'd0;
    else     ts_model <= ts_model + 32'd1;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [32:0] src_q[$];
  logic [32:0] exp_q[$];
  logic [31:0] hs_log[$];
  bit          mon_en = 1'b0;
  int          info_pos = -1;
  bit          in_frame = 1'b0;
  logic [31:0] sb_frames = 32'd0;
  logic [31:0] sb_words = 32'd0;
  logic [15:0] sb_seq = 16'd0;
  logic [31:0] last_w1 = 32'd0;
  bit          have_w1 = 1'b0;
  int          info_pkts = 0;
  bit          prev_stall = 1'b0;
  logic [32:0] prev_word = 33'd0;
  logic        mon_hs;
  logic        mon_sent;
  logic [32:0] mon_w;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      info_pos   = -1;
      in_frame   = 1'b0;
      sb_frames  = 32'd0;
      sb_words   = 32'd0;
      sb_seq     = 16'd0;
      have_w1    = 1'b0;
      info_pkts  = 0;
      prev_stall = 1'b0;
    end else if (mon_en) begin
      if (prev_stall) begin
        check("stall_valid", m_axis.tvalid, 1);
        check("stall_word", {m_axis.tlast, m_axis.tdata}, prev_word);
      end
      mon_hs   = m_axis.tvalid && m_axis.tready;
      mon_sent = 1'b0;
      if (mon_hs) begin
        hs_log.push_back(ts_model);
        if (info_pos < 0 && !in_frame && m_axis.tdata[31:16] == 16'hA501) info_pos = 0;
        if (info_pos >= 0) begin
          case (info_pos)
            0: check("info_w0", m_axis.tdata, {16'hA501, sb_seq});
            1: begin
              check("info_w1_age", ((ts_model - m_axis.tdata) >= 32'd3), 1);
              if (have_w1) check("info_w1_order", (m_axis.tdata > last_w1), 1);
              last_w1 = m_axis.tdata;
              have_w1 = 1'b1;
            end
            2: check("info_w2_frames", m_axis.tdata, sb_frames);
            default: check("info_w3_words", m_axis.tdata, sb_words);
          endcase
          check("info_tlast", m_axis.tlast, (info_pos == 3));
          if (info_pos == 3) begin
            mon_sent  = 1'b1;
            info_pos  = -1;
            sb_seq    = sb_seq + 16'd1;
            info_pkts = info_pkts + 1;
          end else begin
            info_pos = info_pos + 1;
          end
        end else if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL frame_extra: got word 0x%0h, expected no word", {m_axis.tlast, m_axis.tdata});
        end else begin
          mon_w = exp_q.pop_front();
          check("frame_word", {m_axis.tlast, m_axis.tdata}, mon_w);
          sb_words = sb_words + 32'd1;
          if (mon_w[32]) sb_frames = sb_frames + 32'd1;
          in_frame = !mon_w[32];
        end
      end
      check("info_sent", info_sent, mon_sent);
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_word  = {m_axis.tlast, m_axis.tdata};
    end
  end

  // ---------------- cycle driver ----------------
  int ready_pct = 100;
  int valid_pct = 100;
  bit s_hold = 1'b0;

  task automatic cycle(input bit req);
    @(negedge clk);
    info_req = req;
    m_axis.tready = ($urandom_range(99) < ready_pct);
    if (src_q.size() > 0 && (s_hold || $urandom_range(99) < valid_pct)) begin
      s_axis.tvalid = 1'b1;
      {s_axis.tlast, s_axis.tdata} = src_q[0];
    end else begin
      s_axis.tvalid = 1'b0;
    end
    #1;
    s_hold = s_axis.tvalid && !s_axis.tready;
    if (s_axis.tvalid && s_axis.tready) void'(src_q.pop_front());
  endtask

  task automatic push_frame(input int len);
    logic [32:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1), ($urandom() & 32'h7FFF_FFFF)};
      src_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  // ---------------- cycle vector table ----------------
  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        sl;
    logic        rdy;
    logic        req;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        esr;
    logic        esent;
    logic        ebusy;
  } vec_t;

  function automatic vec_t mk(logic sv, logic [31:0] sd, logic sl, logic rdy, logic req,
                              logic ev, logic [31:0] ed, logic el, logic esr, logic esent, logic ebusy);
    vec_t v;
    v.sv = sv; v.sd = sd; v.sl = sl; v.rdy = rdy; v.req = req;
    v.ev = ev; v.ed = ed; v.el = el; v.esr = esr; v.esent = esent; v.ebusy = ebusy;
    return v;
  endfunction

  vec_t vecs[22];

  initial begin
    logic [36:0] act_v;
    logic [36:0] exp_v;
    int guard;
    int base;

    // frame A0..A2, then info packet, then a second info packet stalled for two cycles
    vecs[0]  = mk(1, 32'hA0, 0, 1, 0,  0, 32'h0,          0, 0, 0, 0);
    vecs[1]  = mk(1, 32'hA0, 0, 1, 0,  0, 32'h0,          0, 1, 0, 1);
    vecs[2]  = mk(1, 32'hA1, 0, 1, 0,  1, 32'hA0,         0, 1, 0, 1);
    vecs[3]  = mk(1, 32'hA2, 1, 1, 0,  1, 32'hA1,         0, 1, 0, 1);
    vecs[4]  = mk(0, 32'h0,  0, 1, 0,  1, 32'hA2,         1, 0, 0, 0);
    vecs[5]  = mk(0, 32'h0,  0, 1, 1,  0, 32'h0,          0, 0, 0, 0);
    vecs[6]  = mk(0, 32'h0,  0, 1, 0,  0, 32'h0,          0, 0, 0, 0);
    vecs[7]  = mk(0, 32'h0,  0, 1, 0,  0, 32'h0,          0, 0, 0, 1);
    vecs[8]  = mk(0, 32'h0,  0, 1, 0,  1, 32'hA501_0000,  0, 0, 0, 1);
    vecs[9]  = mk(0, 32'h0,  0, 1, 0,  1, 32'd6,          0, 0, 0, 1);
    vecs[10] = mk(0, 32'h0,  0, 1, 0,  1, 32'd1,          0, 0, 0, 1);
    vecs[11] = mk(0, 32'h0,  0, 1, 0,  1, 32'd3,          1, 0, 1, 0);
    vecs[12] = mk(0, 32'h0,  0, 1, 1,  0, 32'h0,          0, 0, 0, 0);
    vecs[13] = mk(0, 32'h0,  0, 1, 0,  0, 32'h0,          0, 0, 0, 0);
    vecs[14] = mk(0, 32'h0,  0, 1, 0,  0, 32'h0,          0, 0, 0, 1);
    vecs[15] = mk(0, 32'h0,  0, 0, 0,  1, 32'hA501_0001,  0, 0, 0, 1);
    vecs[16] = mk(0, 32'h0,  0, 0, 0,  1, 32'hA501_0001,  0, 0, 0, 1);
    vecs[17] = mk(0, 32'h0,  0, 1, 0,  1, 32'hA501_0001,  0, 0, 0, 1);
    vecs[18] = mk(0, 32'h0,  0, 1, 0,  1, 32'd13,         0, 0, 0, 1);
    vecs[19] = mk(0, 32'h0,  0, 1, 0,  1, 32'd1,          0, 0, 0, 1);
    vecs[20] = mk(0, 32'h0,  0, 1, 0,  1, 32'd3,          1, 0, 1, 0);
    vecs[21] = mk(0, 32'h0,  0, 1, 0,  0, 32'h0,          0, 0, 0, 0);

    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 32'd0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_tvalid", m_axis.tvalid, 0);
    check("rst_tdata", m_axis.tdata, 0);
    check("rst_tlast", m_axis.tlast, 0);
    check("rst_s_tready", s_axis.tready, 0);
    check("rst_info_sent", info_sent, 0);
    check("rst_busy", busy, 0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      s_axis.tvalid = vecs[i].sv;
      s_axis.tdata  = vecs[i].sd;
      s_axis.tlast  = vecs[i].sl;
      m_axis.tready = vecs[i].rdy;
      info_req      = vecs[i].req;
      #1;
      act_v = {m_axis.tvalid, (m_axis.tvalid ? m_axis.tdata : 32'd0), (m_axis.tvalid & m_axis.tlast),
               s_axis.tready, info_sent, busy};
      exp_v = {vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].esr, vecs[i].esent, vecs[i].ebusy};
      check($sformatf("vec[%0d]", i), act_v, exp_v);
    end

    // fresh start for scoreboard-checked phases
    @(negedge clk);
    rst = 1'b1;
    s_axis.tvalid = 1'b0;
    info_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // info request during word 2 of an 8-word frame
    ready_pct = 100;
    valid_pct = 100;
    hs_log.delete();
    base = info_pkts;
    push_frame(8);
    guard = 0;
    while (src_q.size() > 6 && guard < 50) begin cycle(0); guard++; end
    cycle(1);
    while (src_q.size() > 0 && guard < 100) begin cycle(0); guard++; end
    repeat (12) cycle(0);
    check("t3_handshakes", hs_log.size(), 12);
    if (hs_log.size() == 12) begin
      for (int i = 0; i < 7; i++) check($sformatf("t3_frame_gap[%0d]", i), hs_log[i+1] - hs_log[i], 1);
      check("t3_bubble", hs_log[8] - hs_log[7], 2);
      for (int i = 8; i < 11; i++) check($sformatf("t3_info_gap[%0d]", i), hs_log[i+1] - hs_log[i], 1);
    end
    check("t3_info_pkts", info_pkts - base, 1);

    // info_req held across the first transition and into INFO
    base = info_pkts;
    repeat (5) cycle(1);
    repeat (30) cycle(0);
    check("t4_info_pkts", info_pkts - base, 2);

    // random backpressure, random valid, random info requests
    ready_pct = 50;
    valid_pct = 70;
    for (int f = 0; f < 1000; f++) push_frame($urandom_range(6, 1));
    guard = 0;
    while (src_q.size() > 0 && guard < 40000) begin
      cycle($urandom_range(29) == 0);
      guard++;
    end
    if (src_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL random_timeout: %0d words still queued, expected 0", src_q.size());
    end
    ready_pct = 100;
    guard = 0;
    while ((busy || exp_q.size() > 0) && guard < 500) begin cycle(0); guard++; end
    repeat (10) cycle(0);
    check("random_drained", exp_q.size(), 0);
    check("random_idle", busy, 0);

    // reset while info word1 is stalled downstream
    valid_pct = 100;
    cycle(1);
    cycle(0);
    cycle(1);
    cycle(1);
    ready_pct = 0;
    cycle(1);
    check("t6_w1_stalled", {m_axis.tvalid, busy}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("t6_tvalid", m_axis.tvalid, 0);
    check("t6_tdata", m_axis.tdata, 0);
    check("t6_tlast", m_axis.tlast, 0);
    check("t6_s_tready", s_axis.tready, 0);
    check("t6_info_sent", info_sent, 0);
    check("t6_busy", busy, 0);
    info_req = 1'b0;
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    s_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ready_pct = 100;
    for (int i = 0; i < 12; i++) begin
      cycle(0);
      check($sformatf("t6_no_pending[%0d]", i), busy, 0);
    end
    cycle(1);
    repeat (10) cycle(0);
    check("t6_info_pkts", info_pkts, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
